// File: rtl/split_pkg.sv
// Shared definitions for the split constraint stimulus drivers.
// Holds the packed assignment layout (var_0 in the LSBs), the driver FSM
// state type and the LFSR polynomial. No ports.
package split_pkg;

  localparam int unsigned NUM_VARS = 35;

  // Layout: var_0..var_23 are 8 bits wide, var_24..var_34 are 16 bits wide.
  localparam int unsigned NUM_BYTE_VARS = 24;
  localparam int unsigned BYTE_VAR_W    = 8;
  localparam int unsigned HALF_VAR_W    = 16;

  function automatic int unsigned var_width(input int unsigned idx);
    return (idx < NUM_BYTE_VARS) ? BYTE_VAR_W : HALF_VAR_W;
  endfunction

  function automatic int unsigned var_offset(input int unsigned idx);
    if (idx < NUM_BYTE_VARS) begin
      return idx * BYTE_VAR_W;
    end
    return NUM_BYTE_VARS * BYTE_VAR_W + (idx - NUM_BYTE_VARS) * HALF_VAR_W;
  endfunction

  // Total packed width, i.e. the offset just past var_34 (368).
  localparam int unsigned VEC_W  = var_offset(NUM_VARS);
  localparam int unsigned NCHUNK = (VEC_W + 31) / 32;

  // Galois feedback mask applied when the bit shifted out is 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = 32'h0000_0001;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StCheck,
    StOut
  } split_drv_state_t;

endpackage

// File: rtl/split_lfsr32.sv
// 32-bit right-shifting Galois LFSR.
//   clk, rst_n  : clock, asynchronous active-low reset (state -> 32'h1)
//   load, seed  : load seed (a zero seed is replaced by 32'h1; load wins over step)
//   step        : advance one position
//   state_next  : value the register takes on the next step
module split_lfsr32
  import split_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state_next
);

  logic [31:0] state_q;

  always_comb begin
    state_next = {1'b0, state_q[31:1]};
    if (state_q[0]) begin
      state_next = state_next ^ LFSR_POLY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_INIT;
    end else if (load) begin
      // All-zero is the lock-up state of the LFSR.
      state_q <= (seed == 32'h0) ? LFSR_INIT : seed;
    end else if (step) begin
      state_q <= state_next;
    end
  end

endmodule

// File: rtl/split_candidate_driver.sv
// Pseudo-random candidate generator for a combinational split constraint.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, seed_load, seed: begin a search / reseed the LFSR (IDLE only)
//   cand_o, sat_i         : candidate to the constraint, its single-bit result
//   sol_valid/ready/data  : handshake carrying a satisfying assignment
//   busy, done, fail      : status; done/fail are one-cycle pulses on return to IDLE
//   tries                 : candidates checked in the current/last search
module split_candidate_driver #(
  parameter int unsigned VEC_W     = split_pkg::VEC_W,
  parameter int unsigned MAX_TRIES = 1024,
  parameter int unsigned TRY_W     = 16  // 2**TRY_W must exceed MAX_TRIES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  output logic [VEC_W-1:0] cand_o,
  input  logic             sat_i,
  output logic             sol_valid,
  input  logic             sol_ready,
  output logic [VEC_W-1:0] sol_data,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [TRY_W-1:0] tries
);
  import split_pkg::*;

  localparam int unsigned NumChunk = (VEC_W + 31) / 32;
  localparam int unsigned FillW    = (NumChunk > 1) ? $clog2(NumChunk) : 1;

  split_drv_state_t state_q, state_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [VEC_W-1:0] cand_sr_q, cand_sr_d;
  logic [VEC_W-1:0] sol_data_q, sol_data_d;
  logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
  logic             done_q, done_d;
  logic             fail_q, fail_d;

  logic             lfsr_load;
  logic             lfsr_step;
  logic [31:0]      lfsr_next;

  split_lfsr32 u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lfsr_load),
    .seed       (seed),
    .step       (lfsr_step),
    .state_next (lfsr_next)
  );

  // Saturating so a mis-sized budget can never wrap the visible count.
  assign tries_inc = (tries_q == TRY_W'(MAX_TRIES)) ? tries_q : tries_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    cand_sr_d  = cand_sr_q;
    sol_data_d = sol_data_q;
    tries_d    = tries_q;
    done_d     = 1'b0;
    fail_d     = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
        end else if (start) begin
          state_d = StFill;
          tries_d = '0;
          fill_d  = '0;
        end
      end
      StFill: begin
        // Oldest chunk ends up in the MSBs; the top of the first chunk falls off.
        lfsr_step = 1'b1;
        cand_sr_d = {cand_sr_q[VEC_W-33:0], lfsr_next};
        if (fill_q == FillW'(NumChunk - 1)) begin
          state_d = StCheck;
        end else begin
          fill_d = fill_q + 1'b1;
        end
      end
      StCheck: begin
        tries_d = tries_inc;
        if (sat_i) begin
          sol_data_d = cand_sr_q;
          state_d    = StOut;
        end else if (tries_inc == TRY_W'(MAX_TRIES)) begin
          fail_d  = 1'b1;
          state_d = StIdle;
        end else begin
          fill_d  = '0;
          state_d = StFill;
        end
      end
      StOut: begin
        if (sol_ready) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fill_q     <= '0;
      cand_sr_q  <= '0;
      sol_data_q <= '0;
      tries_q    <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      cand_sr_q  <= cand_sr_d;
      sol_data_q <= sol_data_d;
      tries_q    <= tries_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign cand_o    = cand_sr_q;
  assign sol_data  = sol_data_q;
  assign sol_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign fail      = fail_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_split_candidate_driver.sv
// Directed bench for split_candidate_driver with a 4-try budget.
module tb_split_candidate_driver;
  import split_pkg::*;

  localparam int unsigned MaxTries = 4;
  localparam int unsigned TryW     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             seed_load = 1'b0;
  logic [31:0]      seed = 32'h0;
  logic [VEC_W-1:0] cand_o;
  logic             sat_i;
  logic             sol_valid;
  logic             sol_ready = 1'b0;
  logic [VEC_W-1:0] sol_data;
  logic             busy;
  logic             done;
  logic             fail;
  logic [TryW-1:0]  tries;

  int n_checks = 0;
  int n_errors = 0;
  int sat_mode = 1;  // 0: tied low, 1: tied high, 2: cand_o[0]

  logic [31:0]      ref_lfsr;
  logic [VEC_W-1:0] first_sol;

  always #5 clk = ~clk;

  assign sat_i = (sat_mode == 0) ? 1'b0 : (sat_mode == 1) ? 1'b1 : cand_o[0];

  split_candidate_driver #(
    .VEC_W     (VEC_W),
    .MAX_TRIES (MaxTries),
    .TRY_W     (TryW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed_load (seed_load),
    .seed      (seed),
    .cand_o    (cand_o),
    .sat_i     (sat_i),
    .sol_valid (sol_valid),
    .sol_ready (sol_ready),
    .sol_data  (sol_data),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .tries     (tries)
  );

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // Chunk k of a try lands at bits [(11-k)*32 +: 32]; the top 16 bits are dropped.
  task automatic model_cand(output logic [VEC_W-1:0] c);
    logic [12*32-1:0] acc;
    acc = '0;
    for (int k = 0; k < 12; k++) begin
      ref_lfsr = ref_step(ref_lfsr);
      acc[(11 - k) * 32 +: 32] = ref_lfsr;
    end
    c = acc[VEC_W-1:0];
  endtask

  task automatic load_seed(input logic [31:0] s);
    @(negedge clk);
    seed_load = 1'b1;
    seed      = s;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 (start sampled at the end of cycle 0).
  task automatic start_search();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc counts negedges after cycle 1, so cyc == N means cycle N+1.
  task automatic wait_result(output int cyc, output bit v, output bit f);
    cyc = 0;
    v   = 1'b0;
    f   = 1'b0;
    while (!v && !f && cyc < 13 * MaxTries + 10) begin
      @(negedge clk);
      cyc++;
      v = sol_valid;
      f = fail;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (cand_o !== '0) begin n_errors++; $display("FAIL reset_cand got %h want 0", cand_o); end
    n_checks++; if (sol_data !== '0) begin n_errors++; $display("FAIL reset_sol_data got %h want 0", sol_data); end
    n_checks++; if (sol_valid !== 1'b0) begin n_errors++; $display("FAIL reset_sol_valid got %b want 0", sol_valid); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0 || fail !== 1'b0) begin n_errors++; $display("FAIL reset_pulses got done=%b fail=%b want 0 0", done, fail); end
    n_checks++; if (tries !== '0) begin n_errors++; $display("FAIL reset_tries got %0d want 0", tries); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_solution();
    logic [VEC_W-1:0] c;
    int cyc; bit v, f;
    load_seed(32'h5);
    load_seed(32'h0);  // zero seed must fall back to 32'h1
    ref_lfsr  = 32'h1;
    sat_mode  = 1;
    sol_ready = 1'b1;
    model_cand(c);
    start_search();
    wait_result(cyc, v, f);
    n_checks++; if (!v || cyc != 13) begin n_errors++; $display("FAIL first_latency got valid=%b cycle=%0d want valid=1 cycle=14", v, cyc + 1); end
    n_checks++; if (tries !== 16'd1) begin n_errors++; $display("FAIL first_tries got %0d want 1", tries); end
    n_checks++; if (sol_data[367:352] !== 16'h0003) begin n_errors++; $display("FAIL first_chunk0 got %h want 0003", sol_data[367:352]); end
    n_checks++; if (sol_data[351:320] !== 32'hC030_0002) begin n_errors++; $display("FAIL first_chunk1 got %h want c0300002", sol_data[351:320]); end
    n_checks++; if (sol_data[319:288] !== 32'h6018_0001) begin n_errors++; $display("FAIL first_chunk2 got %h want 60180001", sol_data[319:288]); end
    n_checks++; if (sol_data !== c) begin n_errors++; $display("FAIL first_sol_data got %h want %h", sol_data, c); end
    n_checks++; if (cand_o !== c) begin n_errors++; $display("FAIL first_cand got %h want %h", cand_o, c); end
    first_sol = c;
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || sol_valid !== 1'b0) begin n_errors++; $display("FAIL first_done got done=%b busy=%b valid=%b want 1 0 0", done, busy, sol_valid); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL first_done_pulse got %b want 0", done); end
  endtask

  task automatic test_fail();
    logic [VEC_W-1:0] c;
    int cyc; bit v, f;
    sat_mode = 0;
    for (int t = 0; t < int'(MaxTries); t++) model_cand(c);
    start_search();
    wait_result(cyc, v, f);
    // Fourth CHECK is cycle 52; the registered pulse shows with IDLE in cycle 53.
    n_checks++; if (!f || v || cyc != 52) begin n_errors++; $display("FAIL fail_pulse got fail=%b valid=%b cycle=%0d want 1 0 53", f, v, cyc + 1); end
    n_checks++; if (tries !== 16'd4) begin n_errors++; $display("FAIL fail_tries got %0d want 4", tries); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL fail_busy got %b want 0", busy); end
    @(negedge clk);
    n_checks++; if (fail !== 1'b0 || tries !== 16'd4) begin n_errors++; $display("FAIL fail_hold got fail=%b tries=%0d want 0 4", fail, tries); end
  endtask

  task automatic test_model();
    logic [VEC_W-1:0] c;
    int exp_try, cyc; bit v, f;
    load_seed(32'hDEAD_BEEF);
    ref_lfsr  = 32'hDEAD_BEEF;
    sat_mode  = 2;
    sol_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      exp_try = 0;
      for (int t = 1; t <= int'(MaxTries); t++) begin
        model_cand(c);
        if (c[0]) begin exp_try = t; break; end
      end
      start_search();
      wait_result(cyc, v, f);
      if (exp_try != 0) begin
        n_checks++; if (!v || cyc != 13 * exp_try) begin n_errors++; $display("FAIL model_outcome s=%0d got valid=%b cycle=%0d want valid at %0d", s, v, cyc + 1, 13 * exp_try + 1); end
        n_checks++; if (sol_data !== c || sol_data[0] !== 1'b1) begin n_errors++; $display("FAIL model_sol_data s=%0d got %h want %h", s, sol_data, c); end
        n_checks++; if (tries !== TryW'(exp_try)) begin n_errors++; $display("FAIL model_tries s=%0d got %0d want %0d", s, tries, exp_try); end
      end else begin
        n_checks++; if (!f || v || cyc != 13 * int'(MaxTries)) begin n_errors++; $display("FAIL model_exhaust s=%0d got fail=%b valid=%b cycle=%0d", s, f, v, cyc + 1); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [VEC_W-1:0] c;
    int cyc, bad; bit v, f;
    sat_mode  = 1;
    sol_ready = 1'b0;
    model_cand(c);
    start_search();
    wait_result(cyc, v, f);
    n_checks++; if (!v || cyc != 13) begin n_errors++; $display("FAIL bp_latency got valid=%b cycle=%0d want 1 14", v, cyc + 1); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sol_valid !== 1'b1 || sol_data !== c || cand_o !== c || done !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad); end
    sol_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL bp_done got done=%b busy=%b want 1 0", done, busy); end
  endtask

  task automatic test_ignore_busy();
    logic [VEC_W-1:0] c;
    int cyc; bit v;
    load_seed(32'h1234_5678);
    ref_lfsr  = 32'h1234_5678;
    sat_mode  = 1;
    sol_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      model_cand(c);
      start_search();
      cyc = 0;
      v   = 1'b0;
      while (!v && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (cyc == 3 || cyc == 12) begin
          start = 1'b1; seed_load = 1'b1; seed = 32'hFFFF_0000;
        end else begin
          start = 1'b0; seed_load = 1'b0;
        end
        v = sol_valid;
      end
      start = 1'b0; seed_load = 1'b0;
      n_checks++; if (!v || cyc != 13 || sol_data !== c) begin n_errors++; $display("FAIL ignore_busy s=%0d got valid=%b cycle=%0d data=%h want %h", s, v, cyc + 1, sol_data, c); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [VEC_W-1:0] c;
    int cyc; bit v, f;
    sat_mode  = 1;
    sol_ready = 1'b1;
    model_cand(c);
    start_search();
    wait_result(cyc, v, f);
    start = 1'b1;  // held through OUT and into the done cycle
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL b2b_done got done=%b busy=%b want 1 0", done, busy); end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_restart got busy=%b want 1", busy); end
    model_cand(c);
    wait_result(cyc, v, f);
    n_checks++; if (!v || cyc != 13 || sol_data !== c) begin n_errors++; $display("FAIL b2b_second got valid=%b cycle=%0d data=%h want %h", v, cyc, sol_data, c); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [VEC_W-1:0] c;
    int cyc; bit v, f;
    sat_mode  = 1;
    sol_ready = 1'b1;
    start_search();
    repeat (6) @(negedge clk);  // cycle 7, mid-FILL
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || sol_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset_state got busy=%b valid=%b want 0 0", busy, sol_valid); end
    n_checks++; if (cand_o !== '0 || sol_data !== '0) begin n_errors++; $display("FAIL mid_reset_data got cand=%h data=%h want 0", cand_o, sol_data); end
    n_checks++; if (tries !== '0 || done !== 1'b0 || fail !== 1'b0) begin n_errors++; $display("FAIL mid_reset_status got tries=%0d done=%b fail=%b want 0 0 0", tries, done, fail); end
    @(negedge clk);
    rst_n    = 1'b1;
    ref_lfsr = 32'h1;
    model_cand(c);
    start_search();
    wait_result(cyc, v, f);
    n_checks++; if (!v || sol_data !== c || sol_data !== first_sol) begin n_errors++; $display("FAIL mid_reset_restart got valid=%b data=%h want %h", v, sol_data, first_sol); end
    n_checks++; if (tries !== 16'd1) begin n_errors++; $display("FAIL mid_reset_tries got %0d want 1", tries); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_first_solution();
    test_fail();
    test_model();
    test_backpressure();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
